// File: rtl/ap_pkg.sv
// Shared opcodes, pass codes and FSM state encoding for the AP pass sequencer.
package ap_pkg;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_INV  = 2'd1;
    localparam logic [1:0] OP_ABS  = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    localparam logic [2:0] PASS_NONE = 3'd0;
    localparam logic [2:0] PASS_INV  = 3'd3;
    localparam logic [2:0] PASS_COND = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSign,
        StCmp,
        StWr,
        StDone
    } state_e;

    function automatic logic is_busy(state_e st);
        return (st == StLoad) || (st == StSign) || (st == StCmp) || (st == StWr);
    endfunction

endpackage

// File: rtl/ap_pass_sequencer_if.sv
// Decoder-side request/status bundle and array-side control bundle of the sequencer.
interface ap_pass_sequencer_if #(
    parameter int unsigned IDX_W = 3
);
    logic             start;
    logic [1:0]       op;
    logic             hold;
    logic [IDX_W-1:0] col_idx;
    logic             key;
    logic [2:0]       pass;
    logic             abs_opt;
    logic             load_n;
    logic             sign_latch;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, op, hold,
        input  col_idx, key, pass, abs_opt, load_n, sign_latch, busy, done, err
    );

    modport slave (
        input  start, op, hold,
        output col_idx, key, pass, abs_opt, load_n, sign_latch, busy, done, err
    );
endinterface

// File: rtl/ap_col_counter.sv
// Active bit-column index: clear to 0, jump to the MSB column, or step toward it without wrapping.
module ap_col_counter #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned IDX_W      = $clog2(WORD_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_In,
    input  logic             i_clr,
    input  logic             i_set_last,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORD_WIDTH - 1);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_In) begin
        if (!rst_In) begin
            r_idx <= '0;
        end else if (i_set_last) begin
            r_idx <= LastIdx;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc && (r_idx != LastIdx)) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == LastIdx);
endmodule

// File: rtl/ap_pass_sequencer.sv
// Walks bit columns LSB->MSB issuing compare/write cycles (INV, ABS) or a single array load.
module ap_pass_sequencer
    import ap_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = 4,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned IDX_W      = $clog2(WORD_WIDTH)
) (
    input logic          clk,
    input logic          rst_In,
    ap_pass_sequencer_if.slave bus
);
    if (WORD_WIDTH < 2 || DATA_DEPTH < 1) begin : g_param_check
        $error("ap_pass_sequencer: WORD_WIDTH must be >= 2 and DATA_DEPTH >= 1");
    end

    state_e           r_state, w_state_nxt;
    logic [1:0]       r_op, w_op_eff;
    logic             w_accept, w_freeze;
    logic             w_clr, w_set_last, w_inc, w_last;
    logic [IDX_W-1:0] w_col_idx;

    logic             r_key, w_key_nxt;
    logic [2:0]       r_pass, w_pass_nxt;
    logic             r_abs_opt, r_load_n, w_load_n_nxt;
    logic             r_sign_latch, w_sign_latch_nxt;
    logic             r_busy, r_done, r_err;

    assign w_accept = (r_state == StIdle) && bus.start;
    assign w_freeze = bus.hold && is_busy(r_state);
    assign w_op_eff = w_accept ? bus.op : r_op;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (bus.start) begin
                    unique case (bus.op)
                        OP_LOAD: w_state_nxt = StLoad;
                        OP_INV:  w_state_nxt = StCmp;
                        OP_ABS:  w_state_nxt = StSign;
                        OP_RSVD: w_state_nxt = StDone;
                    endcase
                end
            end
            StLoad:  w_state_nxt = StDone;
            StSign:  w_state_nxt = StCmp;
            StCmp:   w_state_nxt = StWr;
            StWr:    w_state_nxt = w_last ? StDone : StCmp;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (w_freeze) begin
            w_state_nxt = r_state;
        end
    end

    // Outputs are registered from the next state; a frozen state keeps key but drops its strobe.
    always_comb begin
        w_key_nxt        = 1'b0;
        w_pass_nxt       = PASS_NONE;
        w_load_n_nxt     = 1'b1;
        w_sign_latch_nxt = 1'b0;
        case (w_state_nxt)
            StLoad: w_load_n_nxt = w_freeze;
            StSign: begin
                w_key_nxt        = 1'b1;
                w_sign_latch_nxt = !w_freeze;
            end
            StCmp:  w_key_nxt = 1'b1;
            StWr: begin
                w_key_nxt = 1'b1;
                if (!w_freeze) begin
                    w_pass_nxt = (w_op_eff == OP_ABS) ? PASS_COND : PASS_INV;
                end
            end
            default: ;
        endcase
    end

    assign w_set_last = w_accept && (bus.op == OP_ABS);
    assign w_clr      = w_accept || ((r_state == StSign) && !w_freeze);
    assign w_inc      = (r_state == StWr) && !w_freeze && !w_last;

    ap_col_counter #(
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_W      (IDX_W)
    ) u_col_counter (
        .clk        (clk),
        .rst_In     (rst_In),
        .i_clr      (w_clr),
        .i_set_last (w_set_last),
        .i_inc      (w_inc),
        .o_idx      (w_col_idx),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_In) begin
        if (!rst_In) begin
            r_state      <= StIdle;
            r_op         <= OP_LOAD;
            r_key        <= 1'b0;
            r_pass       <= PASS_NONE;
            r_abs_opt    <= 1'b0;
            r_load_n     <= 1'b1;
            r_sign_latch <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_key        <= w_key_nxt;
            r_pass       <= w_pass_nxt;
            r_abs_opt    <= is_busy(w_state_nxt) && (w_op_eff == OP_ABS);
            r_load_n     <= w_load_n_nxt;
            r_sign_latch <= w_sign_latch_nxt;
            r_busy       <= is_busy(w_state_nxt);
            r_done       <= (w_state_nxt == StDone);
            if (w_accept) begin
                r_op  <= bus.op;
                r_err <= (bus.op == OP_RSVD);
            end
        end
    end

    assign bus.col_idx    = w_col_idx;
    assign bus.key        = r_key;
    assign bus.pass       = r_pass;
    assign bus.abs_opt    = r_abs_opt;
    assign bus.load_n     = r_load_n;
    assign bus.sign_latch = r_sign_latch;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_ap_pass_sequencer.sv
// Directed bench for ap_pass_sequencer with a two-row cell-array model fed by its outputs.
module tb_ap_pass_sequencer;
    localparam int unsigned WW = 8;
    localparam int unsigned IW = 3;
    localparam logic [7:0]  LD0 = 8'h05;
    localparam logic [7:0]  LD1 = 8'h85;

    logic clk = 1'b0;
    logic rst_In = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    ap_pass_sequencer_if #(.IDX_W(IW)) u_bus ();

    ap_pass_sequencer #(
        .DATA_DEPTH (4),
        .WORD_WIDTH (WW),
        .IDX_W      (IW)
    ) u_dut (
        .clk    (clk),
        .rst_In (rst_In),
        .bus    (u_bus)
    );

    always #5 clk = ~clk;

    // Array model: row 0 and row 1, each with its own sign flag.
    logic [7:0] row0, row1;
    logic       qs0, qs1;
    always @(posedge clk) begin
        if (!u_bus.load_n) begin
            row0 <= LD0;
            row1 <= LD1;
        end
        if (u_bus.sign_latch) begin
            qs0 <= row0[7];
            qs1 <= row1[7];
        end
        if (u_bus.pass == 3'd3 || (u_bus.pass == 3'd4 && qs0)) begin
            row0[u_bus.col_idx] <= ~row0[u_bus.col_idx];
        end
        if (u_bus.pass == 3'd3 || (u_bus.pass == 3'd4 && qs1)) begin
            row1[u_bus.col_idx] <= ~row1[u_bus.col_idx];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {col_idx, key, pass, abs_opt, load_n, sign_latch, busy, done, err}
    function automatic logic [31:0] outs();
        return {19'd0, u_bus.col_idx, u_bus.key, u_bus.pass, u_bus.abs_opt, u_bus.load_n,
                u_bus.sign_latch, u_bus.busy, u_bus.done, u_bus.err};
    endfunction

    function automatic logic [31:0] exp_o(input logic [2:0] col, input logic key,
                                          input logic [2:0] pass, input logic abs_opt,
                                          input logic load_n, input logic sl, input logic busy,
                                          input logic done, input logic err);
        return {19'd0, col, key, pass, abs_opt, load_n, sl, busy, done, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_op(input logic [1:0] op);
        u_bus.start = 1'b1;
        u_bus.op    = op;
        tick();
        u_bus.start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        while (!u_bus.done && cyc < 200) tick();
        check_eq(tag, cyc, exp_cyc);
        tick();
    endtask

    initial begin
        int ndone;
        int dcyc;
        logic [2:0] col;
        u_bus.start = 1'b0;
        u_bus.op    = 2'd0;
        u_bus.hold  = 1'b0;
        #2 rst_In = 1'b0;
        #1 check_eq("reset_outs", outs(), exp_o(0, 0, 0, 0, 1, 0, 0, 0, 0));
        tick();
        tick();
        rst_In = 1'b1;
        tick();
        check_eq("reset_idle", outs(), exp_o(0, 0, 0, 0, 1, 0, 0, 0, 0));

        // LOAD
        start_op(2'd0);
        check_eq("load_c1", outs(), exp_o(0, 0, 0, 0, 0, 0, 1, 0, 0));
        tick();
        check_eq("load_done", outs(), exp_o(0, 0, 0, 0, 1, 0, 0, 1, 0));
        tick();
        check_eq("load_idle", outs(), exp_o(0, 0, 0, 0, 1, 0, 0, 0, 0));
        check_eq("load_row0", row0, LD0);
        check_eq("load_row1", row1, LD1);

        // INV: CMP on odd cycles, WR on even cycles
        start_op(2'd1);
        for (int c = 1; c <= 16; c++) begin
            col = 3'((c - 1) / 2);
            if (c % 2 == 1) check_eq("inv_cmp", outs(), exp_o(col, 1, 0, 0, 1, 0, 1, 0, 0));
            else            check_eq("inv_wr", outs(), exp_o(col, 1, 3, 0, 1, 0, 1, 0, 0));
            tick();
        end
        check_eq("inv_done", outs(), exp_o(7, 0, 0, 0, 1, 0, 0, 1, 0));
        tick();
        check_eq("inv_row0", row0, 8'hFA);
        check_eq("inv_row1", row1, 8'h7A);

        // ABS after reload
        start_op(2'd0);
        wait_done("reload_done_cyc", 2);
        start_op(2'd2);
        check_eq("abs_sign", outs(), exp_o(7, 1, 0, 1, 1, 1, 1, 0, 0));
        tick();
        for (int c = 2; c <= 17; c++) begin
            col = 3'((c - 2) / 2);
            if (c % 2 == 0) check_eq("abs_cmp", outs(), exp_o(col, 1, 0, 1, 1, 0, 1, 0, 0));
            else            check_eq("abs_wr", outs(), exp_o(col, 1, 4, 1, 1, 0, 1, 0, 0));
            tick();
        end
        check_eq("abs_done", outs(), exp_o(7, 0, 0, 0, 1, 0, 0, 1, 0));
        tick();
        check_eq("abs_row0", row0, 8'h05);
        check_eq("abs_row1", row1, 8'h7A);

        // INV with hold sampled at edges 5..7, ahead of column 2's write
        start_op(2'd1);
        tick(); tick(); tick(); tick();
        check_eq("hold3_c5", outs(), exp_o(2, 1, 0, 0, 1, 0, 1, 0, 0));
        u_bus.hold = 1'b1;
        for (int c = 6; c <= 8; c++) begin
            tick();
            check_eq("hold3_held", outs(), exp_o(2, 1, 0, 0, 1, 0, 1, 0, 0));
        end
        u_bus.hold = 1'b0;
        tick();
        check_eq("hold3_wr_c9", outs(), exp_o(2, 1, 3, 0, 1, 0, 1, 0, 0));
        wait_done("hold3_done_cyc", 20);

        // One hold cycle on a WR blanks its repeat, then moves to the next column
        start_op(2'd1);
        tick();
        check_eq("holdwr_c2", outs(), exp_o(0, 1, 3, 0, 1, 0, 1, 0, 0));
        u_bus.hold = 1'b1;
        tick();
        check_eq("holdwr_held", outs(), exp_o(0, 1, 0, 0, 1, 0, 1, 0, 0));
        u_bus.hold = 1'b0;
        tick();
        check_eq("holdwr_c4", outs(), exp_o(1, 1, 0, 0, 1, 0, 1, 0, 0));
        wait_done("holdwr_done_cyc", 18);

        // Hold in LOAD and in SIGN
        start_op(2'd0);
        u_bus.hold = 1'b1;
        tick();
        check_eq("holdld_held", outs(), exp_o(0, 0, 0, 0, 1, 0, 1, 0, 0));
        u_bus.hold = 1'b0;
        tick();
        check_eq("holdld_done", outs(), exp_o(0, 0, 0, 0, 1, 0, 0, 1, 0));
        tick();
        start_op(2'd2);
        u_bus.hold = 1'b1;
        tick();
        check_eq("holdsg_held", outs(), exp_o(7, 1, 0, 1, 1, 0, 1, 0, 0));
        u_bus.hold = 1'b0;
        tick();
        check_eq("holdsg_cmp0", outs(), exp_o(0, 1, 0, 1, 1, 0, 1, 0, 0));
        wait_done("holdsg_done_cyc", 19);

        // Reserved opcode; err persists until the next accepted start
        start_op(2'd3);
        check_eq("rsvd_done", outs(), exp_o(0, 0, 0, 0, 1, 0, 0, 1, 1));
        tick();
        check_eq("rsvd_idle", outs(), exp_o(0, 0, 0, 0, 1, 0, 0, 0, 1));
        start_op(2'd0);
        check_eq("rsvd_cleared", outs(), exp_o(0, 0, 0, 0, 0, 0, 1, 0, 0));
        wait_done("rsvd_load_cyc", 2);

        // Starts while busy or in DONE are dropped
        start_op(2'd1);
        ndone = 0;
        dcyc  = 0;
        for (int c = 1; c <= 24; c++) begin
            u_bus.start = (c == 3 || c == 9 || c == 16 || c == 17);
            u_bus.op    = 2'd0;
            if (u_bus.done) begin
                ndone++;
                dcyc = c;
            end
            tick();
        end
        u_bus.start = 1'b0;
        check_eq("busy_start_ndone", ndone, 1);
        check_eq("busy_start_dcyc", dcyc, 17);
        check_eq("busy_start_idle", outs(), exp_o(7, 0, 0, 0, 1, 0, 0, 0, 0));

        // Reset in cycle 5 of ABS
        start_op(2'd2);
        tick(); tick(); tick(); tick();
        check_eq("rstmid_c5", outs(), exp_o(1, 1, 4, 1, 1, 0, 1, 0, 0));
        rst_In = 1'b0;
        #1 check_eq("rstmid_outs", outs(), exp_o(0, 0, 0, 0, 1, 0, 0, 0, 0));
        tick();
        rst_In = 1'b1;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (u_bus.done) ndone++;
            tick();
        end
        check_eq("rstmid_no_done", ndone, 0);
        start_op(2'd0);
        check_eq("rstmid_load_c1", outs(), exp_o(0, 0, 0, 0, 0, 0, 1, 0, 0));
        wait_done("rstmid_load_cyc", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
